// File: rtl/fix_to_fp_converter.sv
// Signed fixed-point to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest-even; one conversion in flight.
module fix_to_fp_converter #(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // Exponent of the input MSB weight: 2^(IN_W-1-FRAC_W), biased.
    localparam logic [7:0] EXP_INIT = 8'(127 + IN_W - 1 - FRAC_W);

    state_t          state_q,     state_d;
    logic            sign_q,      sign_d;
    logic [IN_W-1:0] mag_q,       mag_d;
    logic [7:0]      exp_q,       exp_d;
    logic [31:0]     out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q,      busy_d;
    logic            in_ready_q,  in_ready_d;

    logic [IN_W-1:0] mag_in;
    logic [22:0]     mant_trunc;
    logic            round_up;
    logic [23:0]     mant_sum;
    logic [22:0]     mant_final;
    logic [7:0]      exp_final;

    // Two's-complement magnitude; the most-negative input wraps to 2^(IN_W-1).
    assign mag_in = in_data[IN_W-1] ? ((~in_data) + {{(IN_W-1){1'b0}}, 1'b1}) : in_data;

    // Mantissa extraction below the hidden bit, with round-to-nearest-even
    // only when the magnitude carries more bits than the fp32 fraction holds.
    generate
        if (IN_W >= 25) begin : g_round
            logic guard;
            logic sticky;
            assign mant_trunc = mag_q[IN_W-2 -: 23];
            assign guard      = mag_q[IN_W-25];
            if (IN_W >= 26) begin : g_sticky
                assign sticky = |mag_q[IN_W-26:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end
            assign round_up = guard & (sticky | mant_trunc[0]);
        end else if (IN_W == 24) begin : g_exact
            assign mant_trunc = mag_q[22:0];
            assign round_up   = 1'b0;
        end else begin : g_pad
            assign mant_trunc = {mag_q[IN_W-2:0], {(24-IN_W){1'b0}}};
            assign round_up   = 1'b0;
        end
    endgenerate

    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign mant_sum   = {1'b0, mant_trunc} + {23'd0, round_up};
    assign mant_final = mant_sum[22:0];
    assign exp_final  = exp_q + {7'd0, mant_sum[23]};

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        exp_d      = exp_q;
        out_data_d = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = in_data[IN_W-1];
                    mag_d  = mag_in;
                    if (mag_in == '0) begin
                        out_data_d = 32'h0000_0000;
                        state_d    = S_DONE;
                    end else begin
                        exp_d   = EXP_INIT;
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (!mag_q[IN_W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                out_data_d = {sign_q, exp_final, mant_final};
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_NORM) || (state_d == S_ROUND);
        in_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= 8'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fix_to_fp_converter.sv
// Directed bench for fix_to_fp_converter (IN_W=32, FRAC_W=16) with an
// expected-result queue filled at stimulus time and drained at each output.
module tb_fix_to_fp_converter;

    localparam int IN_W   = 32;
    localparam int FRAC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_data;
    logic            busy;

    logic [31:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    fix_to_fp_converter #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Present d until accepted; afterwards scribble on in_data to show it is not re-sampled.
    task automatic send(input string tag, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic convert(input string tag, input logic [31:0] d,
                           input logic [31:0] expv, input int lat);
        int          edges;
        logic [31:0] want;
        sb.push_back(expv);
        send(tag, d);
        if (lat > 0) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        end
        wait_valid(edges);
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        want = sb.pop_front();
        check({tag, "_data"}, out_data, want);
        $display("txn %s in=0x%08h out=0x%08h latency=%0d", tag, d, out_data, edges);
        release_out(tag);
    endtask

    initial begin
        int          edges;
        logic [31:0] want;
        logic        saw_valid;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        convert("one",      32'h0001_0000, 32'h3F80_0000, 17);
        convert("neg_one",  32'hFFFF_0000, 32'hBF80_0000, 17);
        convert("most_neg", 32'h8000_0000, 32'hC700_0000, 2);
        convert("zero",     32'h0000_0000, 32'h0000_0000, 0);
        convert("lsb",      32'h0000_0001, 32'h3780_0000, 33);
        convert("one_half", 32'h0001_8000, 32'h3FC0_0000, 17);
        convert("max_pos",  32'h7FFF_FFFF, 32'h4700_0000, 3);
        convert("tie_even", 32'h0100_0001, 32'h4380_0000, 9);
        // 256 + 1.5 ulp: tie between fractions 1 and 2, even choice is 2.
        convert("tie_up",   32'h0100_0003, 32'h4380_0002, 9);

        // Backpressure: hold the result while a new request waits outside.
        sb.push_back(32'h3F80_0000);
        send("bp", 32'h0001_0000);
        wait_valid(edges);
        check("bp_latency", 32'(edges), 32'd17);
        want = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h1234_5678;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, want);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn bp in=0x00010000 out=0x%08h held=10", out_data);
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_stale_accept", 32'(busy | out_valid), 32'd0);

        // Asynchronous reset in the middle of normalisation.
        send("rst_mid", 32'h0000_0001);
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | out_valid;
        end
        check("rst_mid_no_output", 32'(saw_valid), 32'd0);
        $display("txn rst_mid in=0x00000001 discarded");
        convert("after_rst", 32'h0001_0000, 32'h3F80_0000, 17);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
